// File: rtl/scan_seq_pkg.sv
// rtl/scan_seq_pkg.sv - shared constants for the galvo/pixel scan sequencer
package scan_seq_pkg;

  localparam int PIX_W_DEF    = 10;
  localparam int LINE_W_DEF   = 10;
  localparam int SETTLE_W_DEF = 16;
  localparam int TMO_W_DEF    = 20;
  localparam int FRM_W_DEF    = 16;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_GALVO_REQ  = 3'd1;
  localparam logic [2:0] ST_GALVO_WAIT = 3'd2;
  localparam logic [2:0] ST_SETTLE     = 3'd3;
  localparam logic [2:0] ST_GO         = 3'd4;
  localparam logic [2:0] ST_PIX_WAIT   = 3'd5;
  localparam logic [2:0] ST_NEXT       = 3'd6;

endpackage

// File: rtl/scan_sequencer_if.sv
// rtl/scan_sequencer_if.sv - galvo move and pixel capture handshakes
interface scan_sequencer_if;
  logic galvo_req;
  logic galvo_done;
  logic go;
  logic pixel_done;

  modport master (output galvo_req, output go, input galvo_done, input pixel_done);
  modport slave  (input galvo_req, input go, output galvo_done, output pixel_done);
endinterface

// File: rtl/sc_downcnt.sv
// rtl/sc_downcnt.sv - loadable down counter that holds at zero and flags it
module sc_downcnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         enable,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (enable && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - raster scan master: galvo move, settle, capture, index
module scan_sequencer
  import scan_seq_pkg::*;
#(
  parameter int PIX_W    = PIX_W_DEF,
  parameter int LINE_W   = LINE_W_DEF,
  parameter int SETTLE_W = SETTLE_W_DEF,
  parameter int TMO_W    = TMO_W_DEF,
  parameter int FRM_W    = FRM_W_DEF
) (
  input  logic                clk_stream,
  input  logic                rst_stream,
  input  logic                cmd_start,
  input  logic                cmd_stop,
  input  logic                mode_continuous,
  input  logic [PIX_W-1:0]    cfg_pixels,
  input  logic [LINE_W-1:0]   cfg_lines,
  input  logic [SETTLE_W-1:0] cfg_settle,
  input  logic [TMO_W-1:0]    cfg_timeout,
  scan_sequencer_if.master    acq,
  output logic [PIX_W-1:0]    pix_idx,
  output logic [LINE_W-1:0]   line_idx,
  output logic [FRM_W-1:0]    frame_cnt,
  output logic                frame_done,
  output logic                busy,
  output logic                timeout_err,
  input  logic                err_clr,
  output logic [2:0]          state_dbg
);
  logic [2:0]          state;
  logic [PIX_W-1:0]    pix_last;
  logic [LINE_W-1:0]   line_last;
  logic [SETTLE_W-1:0] settle_sh;
  logic [TMO_W-1:0]    tmo_sh;
  logic                cont_sh, stop_pend, settle_zero, tmo_zero;
  logic                end_pix, end_line, stopping, latch_cfg, tmo_expired;

  always_comb begin
    end_pix     = (pix_idx == pix_last);
    end_line    = (line_idx == line_last);
    stopping    = stop_pend | cmd_stop;
    latch_cfg   = (state == ST_IDLE && cmd_start && !cmd_stop) ||
                  (state == ST_NEXT && end_pix && end_line && cont_sh && !stopping);
    tmo_expired = (tmo_sh != '0) && tmo_zero;
  end

  // Counts are stored as last-index so a zero count behaves as one.
  always_ff @(posedge clk_stream) begin
    if (rst_stream) begin
      pix_last  <= '0;
      line_last <= '0;
      settle_sh <= '0;
      tmo_sh    <= '0;
      cont_sh   <= 1'b0;
    end else if (latch_cfg) begin
      pix_last  <= (cfg_pixels == '0) ? '0 : cfg_pixels - PIX_W'(1);
      line_last <= (cfg_lines == '0) ? '0 : cfg_lines - LINE_W'(1);
      settle_sh <= cfg_settle;
      tmo_sh    <= cfg_timeout;
      cont_sh   <= mode_continuous;
    end
  end

  // Both counters load N-1 so the zero flag marks the Nth cycle in the state.
  sc_downcnt #(.W(SETTLE_W)) u_settle (
    .clk(clk_stream), .rst(rst_stream),
    .load(state == ST_GALVO_WAIT && acq.galvo_done),
    .value(settle_sh - SETTLE_W'(1)),
    .enable(state == ST_SETTLE),
    .zero(settle_zero)
  );

  sc_downcnt #(.W(TMO_W)) u_timeout (
    .clk(clk_stream), .rst(rst_stream),
    .load(state == ST_GO),
    .value(tmo_sh - TMO_W'(1)),
    .enable(state == ST_PIX_WAIT),
    .zero(tmo_zero)
  );

  always_ff @(posedge clk_stream) begin
    if (rst_stream) begin
      state       <= ST_IDLE;
      pix_idx     <= '0;
      line_idx    <= '0;
      frame_cnt   <= '0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      stop_pend   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          stop_pend <= 1'b0;
          if (cmd_start && !cmd_stop) begin
            state    <= ST_GALVO_REQ;
            pix_idx  <= '0;
            line_idx <= '0;
          end
        end
        ST_GALVO_REQ: state <= cmd_stop ? ST_IDLE : ST_GALVO_WAIT;
        ST_GALVO_WAIT: begin
          if (cmd_stop) state <= ST_IDLE;
          else if (acq.galvo_done) state <= (settle_sh == '0) ? ST_GO : ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cmd_stop) state <= ST_IDLE;
          else if (settle_zero) state <= ST_GO;
        end
        ST_GO: begin
          if (cmd_stop) stop_pend <= 1'b1;
          state <= ST_PIX_WAIT;
        end
        ST_PIX_WAIT: begin
          if (cmd_stop) stop_pend <= 1'b1;
          if (acq.pixel_done) begin
            state <= ST_NEXT;
          end else if (tmo_expired) begin
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_NEXT: begin
          state <= stopping ? ST_IDLE : ST_GALVO_REQ;
          if (!end_pix) begin
            pix_idx <= pix_idx + PIX_W'(1);
          end else begin
            pix_idx <= '0;
            if (!end_line) begin
              line_idx <= line_idx + LINE_W'(1);
            end else begin
              line_idx   <= '0;
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + FRM_W'(1);
              if (!cont_sh) state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign acq.galvo_req = (state == ST_GALVO_REQ);
  assign acq.go        = (state == ST_GO);
  assign busy          = (state != ST_IDLE);
  assign state_dbg     = state;
endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - scoreboard bench for scan_sequencer
module tb_scan_sequencer;
  import scan_seq_pkg::*;

  logic        clk_stream = 1'b0;
  logic        rst_stream = 1'b1;
  logic        cmd_start = 1'b0, cmd_stop = 1'b0, mode_continuous = 1'b0, err_clr = 1'b0;
  logic [9:0]  cfg_pixels = '0;
  logic [9:0]  cfg_lines = '0;
  logic [15:0] cfg_settle = '0;
  logic [19:0] cfg_timeout = '0;
  logic [9:0]  pix_idx;
  logic [9:0]  line_idx;
  logic [15:0] frame_cnt;
  logic        frame_done, busy, timeout_err;
  logic [2:0]  state_dbg;

  scan_sequencer_if acq ();

  scan_sequencer dut (
    .clk_stream(clk_stream), .rst_stream(rst_stream),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .mode_continuous(mode_continuous),
    .cfg_pixels(cfg_pixels), .cfg_lines(cfg_lines), .cfg_settle(cfg_settle),
    .cfg_timeout(cfg_timeout), .acq(acq),
    .pix_idx(pix_idx), .line_idx(line_idx), .frame_cnt(frame_cnt),
    .frame_done(frame_done), .busy(busy), .timeout_err(timeout_err),
    .err_clr(err_clr), .state_dbg(state_dbg)
  );

  always #2 clk_stream = ~clk_stream;

  typedef struct { int pix; int line; } pos_t;
  pos_t go_q[$];
  int   fd_q[$];
  pos_t mon_e;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, gd_cyc = 0, go_count = 0, fd_count = 0, pw_count = 0;
  int exp_settle = 0;
  int pix_lat = 1;
  int g_pend = 0, p_cnt = 0;
  bit stray_g = 1'b0, stray_p = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Responder: galvo_done one cycle after galvo_req, pixel_done pix_lat cycles after go (0 = never).
  initial begin
    acq.galvo_done = 1'b0;
    acq.pixel_done = 1'b0;
    forever begin
      @(negedge clk_stream);
      acq.galvo_done = (g_pend != 0) | stray_g;
      g_pend = int'(acq.galvo_req);
      acq.pixel_done = stray_p;
      if (p_cnt != 0) begin
        p_cnt--;
        if (p_cnt == 0) acq.pixel_done = 1'b1;
      end
      if (acq.go && pix_lat != 0) p_cnt = pix_lat;
    end
  end

  // Monitor: cyc is the index of the edge just passed.
  always @(posedge clk_stream) begin
    #1;
    cyc++;
    if (acq.galvo_done) gd_cyc = cyc;
    if (state_dbg == ST_PIX_WAIT) pw_count++;
    if (acq.go) begin
      go_count++;
      if (go_q.size() == 0) begin
        check("go_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = go_q.pop_front();
        check("go_pix_idx", 64'(pix_idx), 64'(mon_e.pix));
        check("go_line_idx", 64'(line_idx), 64'(mon_e.line));
        check("galvo_to_go_cycles", 64'(cyc + 1 - gd_cyc), 64'(exp_settle + 1));
      end
    end
    if (frame_done) begin
      fd_count++;
      if (fd_q.size() == 0) begin
        check("frame_done_unexpected", 64'd1, 64'd0);
      end else begin
        check("frame_cnt_at_done", 64'(frame_cnt), 64'(fd_q.pop_front()));
        check("idx_clear_at_done", 64'({pix_idx, line_idx}), 64'd0);
      end
    end
  end

  task automatic clear_counts();
    go_count = 0; fd_count = 0; pw_count = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_stream);
    rst_stream = 1'b1;
    @(negedge clk_stream);
    rst_stream = 1'b0;
    clear_counts();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_galvo_req"}, 64'(acq.galvo_req), 64'd0);
    check({tag, "_go"}, 64'(acq.go), 64'd0);
    check({tag, "_pix_idx"}, 64'(pix_idx), 64'd0);
    check({tag, "_line_idx"}, 64'(line_idx), 64'd0);
    check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
    check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
    check({tag, "_state"}, 64'(state_dbg), 64'(ST_IDLE));
  endtask

  task automatic push_frame(input int p, input int l);
    int pp = (p == 0) ? 1 : p;
    int ll = (l == 0) ? 1 : l;
    for (int j = 0; j < ll; j++)
      for (int i = 0; i < pp; i++)
        go_q.push_back('{pix: i, line: j});
  endtask

  task automatic start_scan(input int p, input int l, input int s, input int t, input bit cont);
    cfg_pixels = 10'(p); cfg_lines = 10'(l); cfg_settle = 16'(s);
    cfg_timeout = 20'(t); mode_continuous = cont; exp_settle = s;
    @(negedge clk_stream); cmd_start = 1'b1;
    @(negedge clk_stream); cmd_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 5000) begin @(negedge clk_stream); n++; end
    check({tag, "_reach_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s);
    int n = 0;
    while (state_dbg != s && n < 5000) begin @(negedge clk_stream); n++; end
    check({tag, "_reach_state"}, 64'(state_dbg), 64'(s));
  endtask

  task automatic wait_go(input string tag, input int cnt);
    int n = 0;
    while (go_count < cnt && n < 5000) begin @(negedge clk_stream); n++; end
    check({tag, "_go_reached"}, 64'(go_count), 64'(cnt));
  endtask

  initial begin
    repeat (3) @(negedge clk_stream);
    rst_stream = 1'b0;
    @(negedge clk_stream);
    check_all_zero("reset");

    // Single frame 3x2, settle 5
    do_reset();
    push_frame(3, 2); fd_q.push_back(1);
    start_scan(3, 2, 5, 0, 1'b0);
    wait_idle("single");
    check("single_go_count", 64'(go_count), 64'd6);
    check("single_frame_done_count", 64'(fd_count), 64'd1);
    check("single_frame_cnt", 64'(frame_cnt), 64'd1);

    // Continuous 2x1; stop lands in the GO of the 6th pixel, finishing frame 3
    do_reset();
    for (int f = 0; f < 3; f++) begin push_frame(2, 1); fd_q.push_back(f + 1); end
    start_scan(2, 1, 2, 0, 1'b1);
    wait_go("cont", 6);
    cmd_stop = 1'b1; @(negedge clk_stream); cmd_stop = 1'b0;
    wait_idle("cont");
    check("cont_go_count", 64'(go_count), 64'd6);
    check("cont_frame_done_count", 64'(fd_count), 64'd3);
    check("cont_frame_cnt", 64'(frame_cnt), 64'd3);
    check("cont_idx", 64'({pix_idx, line_idx}), 64'd0);

    // Timeout 10 with pixel_done withheld
    do_reset();
    pix_lat = 0;
    push_frame(1, 1);
    start_scan(1, 1, 0, 10, 1'b0);
    wait_idle("tmo");
    check("tmo_err_set", 64'(timeout_err), 64'd1);
    check("tmo_pix_wait_cycles", 64'(pw_count), 64'd10);
    check("tmo_no_frame_done", 64'(fd_count), 64'd0);
    @(negedge clk_stream); err_clr = 1'b1;
    @(negedge clk_stream); err_clr = 1'b0;
    check("err_clr", 64'(timeout_err), 64'd0);
    // pixel_done on the 10th PIX_WAIT cycle beats expiry
    clear_counts();
    pix_lat = 10;
    push_frame(1, 1); fd_q.push_back(1);
    start_scan(1, 1, 0, 10, 1'b0);
    wait_idle("tmo_race");
    check("tmo_race_no_err", 64'(timeout_err), 64'd0);
    check("tmo_race_pix_wait_cycles", 64'(pw_count), 64'd10);
    check("tmo_race_frame_done", 64'(fd_count), 64'd1);
    pix_lat = 1;

    // Stop during the second pixel's settle
    do_reset();
    push_frame(1, 1);
    start_scan(3, 1, 8, 0, 1'b0);
    wait_go("stop", 1);
    wait_state("stop_settle", ST_SETTLE);
    cmd_stop = 1'b1; @(negedge clk_stream); cmd_stop = 1'b0;
    check("stop_state_idle", 64'(state_dbg), 64'(ST_IDLE));
    repeat (12) @(negedge clk_stream);
    check("stop_no_go", 64'(go_count), 64'd1);
    check("stop_pix_idx", 64'(pix_idx), 64'd1);
    check("stop_line_idx", 64'(line_idx), 64'd0);

    // Zero configuration
    do_reset();
    push_frame(0, 0); fd_q.push_back(1);
    start_scan(0, 0, 0, 0, 1'b0);
    wait_idle("zero");
    check("zero_go_count", 64'(go_count), 64'd1);
    check("zero_frame_done", 64'(fd_count), 64'd1);

    // Stray handshakes in IDLE
    clear_counts();
    @(negedge clk_stream); stray_g = 1'b1; stray_p = 1'b1;
    repeat (2) @(negedge clk_stream);
    stray_g = 1'b0; stray_p = 1'b0;
    repeat (3) @(negedge clk_stream);
    check("stray_state", 64'(state_dbg), 64'(ST_IDLE));
    check("stray_go", 64'(go_count), 64'd0);
    check("stray_frame_cnt", 64'(frame_cnt), 64'd1);

    // Reset in the middle of PIX_WAIT
    pix_lat = 0;
    push_frame(1, 1);
    start_scan(2, 1, 0, 0, 1'b0);
    wait_state("rst_mid", ST_PIX_WAIT);
    rst_stream = 1'b1;
    @(negedge clk_stream);
    check_all_zero("rst_mid");
    rst_stream = 1'b0;
    pix_lat = 1;
    repeat (3) @(negedge clk_stream);

    check("go_queue_drained", 64'(go_q.size()), 64'd0);
    check("frame_queue_drained", 64'(fd_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
